sequential_multiplier_32bit: RTL



---
 rtl/alu_pkg.sv | 20 ++
 rtl/mult_control_unit.sv | 66 ++++++
 rtl/sequential_multiplier_32bit.sv | 69 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the sequential multiplier
package alu_pkg;

  // Default operand width and iteration-counter width; counter must hold WIDTH.
  localparam int ALU_WIDTH = 32;
  localparam int ALU_CNT_W = 6;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // ALU operation codes; the ALU control selects this unit on ALU_OP_MUL.
  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_MUL = 4'h2;

endpackage

// File: rtl/mult_control_unit.sv
// rtl/mult_control_unit.sv - FSM and iteration counter for the shift-add multiplier
module mult_control_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift_add,
  output logic busy,
  output logic done,
  output logic product_we
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mult_state_t      state;
  logic [CNT_W-1:0] count;

  // start is honoured only when no operation is in flight (IDLE or DONE).
  assign load       = start && ((state == IDLE) || (state == DONE));
  assign shift_add  = (state == CALC);
  // The last iteration writes the product so it is valid in the DONE cycle.
  assign product_we = (state == CALC) && (count == LAST_ITER);

  // State, counter and registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sequential_multiplier_32bit.sv
// rtl/sequential_multiplier_32bit.sv - unsigned multi-cycle shift-add multiplier
module sequential_multiplier_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic                 load;
  logic                 shift_add;
  logic                 product_we;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH:0]       sum;

  mult_control_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load       (load),
    .shift_add  (shift_add),
    .busy       (busy),
    .done       (done),
    .product_we (product_we)
  );

  // One iteration: add mcand into the upper half when the multiplier LSB is set,
  // keeping the carry, then shift the whole accumulator right by one.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // Operand capture on an accepted start, otherwise iterate while in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (shift_add) begin
      acc   <= acc_next;
    end
  end

  // Product register: written only by the final iteration, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (product_we) begin
      product <= acc_next;
    end
  end

endmodule
